// File: rtl/snake_frame_scanner.sv
// -----------------------------------------------------------------------------
// snake_frame_scanner
//
// Takes a snapshot of the snake game field on request and streams it to the
// display driver as a raster of pixels. Each field cell is expanded to
// CELL_PX x CELL_PX pixels. The pixel stream uses a valid/ready handshake so
// the display side can stall without tearing the frame.
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   field      in   live field, 3 bits per cell, row-major, cell (x,y) at
//                   bit offset (y*SIZE_X+x)*3
//   frame_req  in   start-of-frame request (pulse or level)
//   busy       out  frame in progress, snapshot held
//   frame_done out  one-cycle pulse after the last pixel is accepted
//   pix_valid  out  pixel payload valid
//   pix_ready  in   downstream accepts pixel
//   pix_color  out  pixel colour (RGB 4:4:4 at default width)
//   pix_sof    out  first pixel of frame
//   pix_eol    out  last pixel of a raster line
//   pix_eof    out  last pixel of frame
// -----------------------------------------------------------------------------
module snake_frame_scanner #(
   parameter logic [7:0] SIZE_X     = 8'd10,
   parameter logic [7:0] SIZE_Y     = 8'd10,
   parameter int         FIELD_SIZE = int'(SIZE_X) * int'(SIZE_Y) * 3,
   parameter int         CELL_PX    = 4,
   parameter int         COLOR_W    = 12
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FIELD_SIZE-1:0] field,
   input  logic                  frame_req,
   output logic                  busy,
   output logic                  frame_done,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic [COLOR_W-1:0]    pix_color,
   output logic                  pix_sof,
   output logic                  pix_eol,
   output logic                  pix_eof
);

   localparam int NX    = int'(SIZE_X);
   localparam int NY    = int'(SIZE_Y);
   localparam int CX_W  = (NX > 1) ? $clog2(NX) : 1;
   localparam int CY_W  = (NY > 1) ? $clog2(NY) : 1;
   localparam int SUB_W = (CELL_PX > 1) ? $clog2(CELL_PX) : 1;
   localparam int OFF_W = (FIELD_SIZE > 1) ? $clog2(FIELD_SIZE) : 1;

   localparam logic [CX_W-1:0]  CX_LAST  = CX_W'(NX - 1);
   localparam logic [CY_W-1:0]  CY_LAST  = CY_W'(NY - 1);
   localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(CELL_PX - 1);

   localparam logic [COLOR_W-1:0] COL_SNAKE   = COLOR_W'(12'h0F0);
   localparam logic [COLOR_W-1:0] COL_APPLE   = COLOR_W'(12'hF00);
   localparam logic [COLOR_W-1:0] COL_INVALID = COLOR_W'(12'hF0F);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t                state_reg;
   logic [FIELD_SIZE-1:0] snapshot_reg;
   logic [CX_W-1:0]       cell_x_reg;
   logic [CY_W-1:0]       cell_y_reg;
   logic [SUB_W-1:0]      sub_x_reg;
   logic [SUB_W-1:0]      sub_y_reg;

   // Position and payload of the pixel that will be presented next.
   logic [CX_W-1:0]       cell_x_next;
   logic [CY_W-1:0]       cell_y_next;
   logic [SUB_W-1:0]      sub_x_next;
   logic [SUB_W-1:0]      sub_y_next;
   logic [OFF_W-1:0]      cell_off;
   logic [2:0]            cell_code;
   logic [COLOR_W-1:0]    color_next;
   logic                  eol_next;
   logic                  eof_next;

   function automatic logic [COLOR_W-1:0] code_color(input logic [2:0] code);
      logic [COLOR_W-1:0] c;
      case (code)
         3'b000:                      c = '0;
         3'b001, 3'b010,
         3'b011, 3'b100:              c = COL_SNAKE;
         3'b101:                      c = COL_APPLE;
         default:                     c = COL_INVALID;
      endcase
      return c;
   endfunction

   // In LOAD the counters already sit at (0,0), so the next pixel is the
   // current position; in SCAN it is the raster successor of the current one.
   always_comb begin
      cell_x_next = cell_x_reg;
      cell_y_next = cell_y_reg;
      sub_x_next  = sub_x_reg;
      sub_y_next  = sub_y_reg;
      if (state_reg == SCAN) begin
         if (sub_x_reg != SUB_LAST) begin
            sub_x_next = sub_x_reg + 1'b1;
         end else begin
            sub_x_next = '0;
            if (cell_x_reg != CX_LAST) begin
               cell_x_next = cell_x_reg + 1'b1;
            end else begin
               // End of a raster line: column counters clear, row advances.
               cell_x_next = '0;
               if (sub_y_reg != SUB_LAST) begin
                  sub_y_next = sub_y_reg + 1'b1;
               end else begin
                  sub_y_next = '0;
                  if (cell_y_reg != CY_LAST) begin
                     cell_y_next = cell_y_reg + 1'b1;
                  end else begin
                     cell_y_next = '0;
                  end
               end
            end
         end
      end
   end

   always_comb begin
      cell_off   = OFF_W'((32'(cell_y_next) * NX + 32'(cell_x_next)) * 3);
      cell_code  = snapshot_reg[cell_off +: 3];
      color_next = code_color(cell_code);
      eol_next   = (cell_x_next == CX_LAST) && (sub_x_next == SUB_LAST);
      eof_next   = eol_next && (cell_y_next == CY_LAST) && (sub_y_next == SUB_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= IDLE;
         snapshot_reg <= '0;
         cell_x_reg   <= '0;
         cell_y_reg   <= '0;
         sub_x_reg    <= '0;
         sub_y_reg    <= '0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
         pix_valid    <= 1'b0;
         pix_color    <= '0;
         pix_sof      <= 1'b0;
         pix_eol      <= 1'b0;
         pix_eof      <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (frame_req) begin
                  snapshot_reg <= field;
                  busy         <= 1'b1;
                  cell_x_reg   <= '0;
                  cell_y_reg   <= '0;
                  sub_x_reg    <= '0;
                  sub_y_reg    <= '0;
                  state_reg    <= LOAD;
               end
            end
            LOAD: begin
               pix_valid <= 1'b1;
               pix_color <= color_next;
               pix_sof   <= 1'b1;
               pix_eol   <= eol_next;
               pix_eof   <= eof_next;
               state_reg <= SCAN;
            end
            SCAN: begin
               // Payload only moves on a transfer, so a stalled pixel holds.
               if (pix_valid && pix_ready) begin
                  if (pix_eof) begin
                     pix_valid  <= 1'b0;
                     pix_color  <= '0;
                     pix_sof    <= 1'b0;
                     pix_eol    <= 1'b0;
                     pix_eof    <= 1'b0;
                     busy       <= 1'b0;
                     frame_done <= 1'b1;
                     cell_x_reg <= '0;
                     cell_y_reg <= '0;
                     sub_x_reg  <= '0;
                     sub_y_reg  <= '0;
                     state_reg  <= DONE;
                  end else begin
                     cell_x_reg <= cell_x_next;
                     cell_y_reg <= cell_y_next;
                     sub_x_reg  <= sub_x_next;
                     sub_y_reg  <= sub_y_next;
                     pix_color  <= color_next;
                     pix_sof    <= 1'b0;
                     pix_eol    <= eol_next;
                     pix_eof    <= eof_next;
                  end
               end
            end
            DONE: begin
               // frame_req is not looked at here; a held request is picked
               // up in IDLE on the following edge.
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_snake_frame_scanner.sv
// -----------------------------------------------------------------------------
// tb_snake_frame_scanner
//
// Directed bench for snake_frame_scanner at default parameters (10x10 field,
// 4x4 pixels per cell, 12-bit colour). Expected pixels come from a reference
// lookup on the bench's own copy of the field, plus hand-computed constants.
// -----------------------------------------------------------------------------
module tb_snake_frame_scanner;

   localparam int SX   = 10;
   localparam int SY   = 10;
   localparam int CP   = 4;
   localparam int FS   = SX * SY * 3;
   localparam int W    = SX * CP;
   localparam int H    = SY * CP;
   localparam int NPIX = W * H;

   logic          clk = 1'b0;
   logic          rst;
   logic [FS-1:0] field;
   logic          frame_req;
   logic          busy;
   logic          frame_done;
   logic          pix_valid;
   logic          pix_ready;
   logic [11:0]   pix_color;
   logic          pix_sof;
   logic          pix_eol;
   logic          pix_eof;

   int checks = 0;
   int errors = 0;

   snake_frame_scanner #(
      .SIZE_X     (8'd10),
      .SIZE_Y     (8'd10),
      .FIELD_SIZE (FS),
      .CELL_PX    (CP),
      .COLOR_W    (12)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .field      (field),
      .frame_req  (frame_req),
      .busy       (busy),
      .frame_done (frame_done),
      .pix_valid  (pix_valid),
      .pix_ready  (pix_ready),
      .pix_color  (pix_color),
      .pix_sof    (pix_sof),
      .pix_eol    (pix_eol),
      .pix_eof    (pix_eof)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [FS-1:0] put(input logic [FS-1:0] f, input int x, input int y,
                                         input logic [2:0] c);
      logic [FS-1:0] r;
      r = f;
      r[(y * SX + x) * 3 +: 3] = c;
      return r;
   endfunction

   function automatic logic [11:0] ref_color(input logic [FS-1:0] f, input int px, input int py);
      logic [2:0] code;
      code = f[((py / CP) * SX + (px / CP)) * 3 +: 3];
      if (code == 3'd0)      return 12'h000;
      else if (code <= 3'd4) return 12'h0F0;
      else if (code == 3'd5) return 12'hF00;
      else                   return 12'hF0F;
   endfunction

   // spot: 1 = content-mapping constants, 2 = invalid cell (9,9), 3 = all apple
   task automatic run_frame(input string name, input bit started, input int pct,
                            input int mod_at, input int req_a, input int req_b,
                            input int rst_at, input bit hold_req, input int spot);
      logic [FS-1:0] ref_fld;
      logic [14:0]   held;
      bit            stalled;
      bit            ready;
      int            xfers, eols, dones, cyc, px, py;
      xfers = 0; eols = 0; dones = 0; cyc = 0; px = 0; py = 0;
      stalled = 1'b0;
      held = '0;
      ref_fld = field;
      if (!started) begin
         frame_req = 1'b1;
         @(negedge clk);
      end
      frame_req = 1'b0;
      check({name, "_start_busy"}, {31'd0, busy}, 32'd1);
      check({name, "_start_valid"}, {31'd0, pix_valid}, 32'd0);

      while (xfers < NPIX && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (frame_done) dones++;
         if (stalled) begin
            check({name, "_stall_valid"}, {31'd0, pix_valid}, 32'd1);
            check({name, "_stall_hold"}, {17'd0, pix_sof, pix_eol, pix_eof, pix_color}, {17'd0, held});
         end
         if (rst_at >= 0 && xfers == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check({name, "_rst_valid"}, {31'd0, pix_valid}, 32'd0);
            check({name, "_rst_busy"}, {31'd0, busy}, 32'd0);
            check({name, "_rst_done"}, {31'd0, frame_done}, 32'd0);
            @(negedge clk);
            check({name, "_rst_done2"}, {31'd0, frame_done}, 32'd0);
            $display("frame %s: reset after %0d transfers", name, xfers);
            return;
         end
         frame_req = (xfers == req_a) || (xfers == req_b);
         if (mod_at >= 0 && xfers == mod_at) begin
            for (int i = 0; i < SX * SY; i++) field[i * 3 +: 3] = 3'b101;
         end
         ready = ($urandom_range(0, 99) < pct);
         pix_ready = ready;
         stalled = pix_valid && !ready;
         held = {pix_sof, pix_eol, pix_eof, pix_color};
         if (pix_valid && ready) begin
            check({name, "_color"}, {20'd0, pix_color}, {20'd0, ref_color(ref_fld, px, py)});
            check({name, "_flags"}, {29'd0, pix_sof, pix_eol, pix_eof},
                  {29'd0, (px == 0 && py == 0), (px == W - 1), (px == W - 1 && py == H - 1)});
            if (spot == 1) begin
               if (px == 0 && py == 0)   check("map_px0_0", {20'd0, pix_color}, 32'hF00);
               if (px == 4 && py == 4)   check("map_px4_4", {20'd0, pix_color}, 32'h0F0);
               if (px == 3 && py == 4)   check("map_px3_4", {20'd0, pix_color}, 32'h000);
               if (px == 39 && py == 39) check("map_px39_39", {17'd0, pix_sof, pix_eol, pix_eof, pix_color}, 32'h3000);
            end else if (spot == 2) begin
               if (px >= 36 && py >= 36) check("invalid_cell", {20'd0, pix_color}, 32'hF0F);
            end else if (spot == 3) begin
               check("all_apple", {20'd0, pix_color}, 32'hF00);
            end
            if (pix_eol) eols++;
            xfers++;
            if (px == W - 1) begin
               px = 0;
               py++;
            end else begin
               px++;
            end
         end
      end

      check({name, "_transfers"}, xfers, NPIX);
      check({name, "_eol_count"}, eols, H);
      check({name, "_early_done"}, dones, 0);
      frame_req = hold_req;
      @(negedge clk);
      check({name, "_done_pulse"}, {29'd0, frame_done, busy, pix_valid}, 32'b100);
      @(negedge clk);
      check({name, "_done_end"}, {30'd0, frame_done, busy}, 32'b00);
      @(negedge clk);
      check({name, "_rereq_busy"}, {31'd0, busy}, {31'd0, hold_req});
      frame_req = 1'b0;
      $display("frame %s: transfers %0d eol %0d cycles %0d", name, xfers, eols, cyc);
   endtask

   initial begin
      logic [FS-1:0] f2;
      f2 = '0;
      f2 = put(f2, 0, 0, 3'b101);
      for (int x = 1; x <= 4; x++) f2 = put(f2, x, 1, 3'b010);

      // Reset held with frame_req high: everything stays quiet.
      field     = f2;
      rst       = 1'b1;
      frame_req = 1'b1;
      pix_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("reset_outputs", {17'd0, busy, frame_done, pix_valid, pix_sof, pix_eol, pix_eof, pix_color[8:0]}, 32'd0);
         check("reset_color", {20'd0, pix_color}, 32'd0);
      end
      rst = 1'b0;
      @(negedge clk);  // frame_req sampled in IDLE on this edge

      run_frame("map", 1'b1, 100, -1, -1, -1, -1, 1'b0, 1);
      run_frame("backpressure", 1'b0, 30, -1, -1, -1, -1, 1'b0, 0);
      run_frame("snap_iso", 1'b0, 100, 100, -1, -1, -1, 1'b0, 0);
      run_frame("apple_all", 1'b0, 100, -1, -1, -1, -1, 1'b0, 3);

      field = put(f2, 9, 9, 3'b110);
      run_frame("req_ignore", 1'b0, 100, -1, 10, 1599, -1, 1'b1, 2);
      run_frame("req_held", 1'b1, 100, -1, -1, -1, -1, 1'b0, 2);

      field = f2;
      run_frame("rst_mid", 1'b0, 100, -1, -1, -1, 500, 1'b0, 0);
      run_frame("after_rst", 1'b0, 100, -1, -1, -1, -1, 1'b0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/snake_frame_scanner.md
Name: snake_frame_scanner

Overview:
- Downstream consumer of the snake game field vector: 3 bits per cell, row-major, cell (x,y) at bit offset (y*SIZE_X+x)*3.
- On request, takes a snapshot of the field and streams it to the display driver as a raster of pixels. Each cell is expanded to CELL_PX x CELL_PX pixels.
- Uses a valid/ready handshake, so the display side can apply backpressure without tearing the frame.

Parameters:
- SIZE_X, 8'd10, field width in cells
- SIZE_Y, 8'd10, field height in cells
- FIELD_SIZE, SIZE_X*SIZE_Y*3, field vector width
- CELL_PX, 4, pixels per cell edge (>=1)
- COLOR_W, 12, pixel colour width (RGB 4:4:4)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- field  in  FIELD_SIZE  live field from the game core
- frame_req  in  1  start-of-frame request, pulse or level
- busy  out  1  frame in progress (snapshot held)
- frame_done  out  1  one-cycle pulse after the last pixel is accepted
- pix_valid  out  1  pixel payload valid
- pix_ready  in  1  downstream accepts pixel
- pix_color  out  COLOR_W  pixel colour
- pix_sof  out  1  first pixel of frame
- pix_eol  out  1  last pixel of a raster line
- pix_eof  out  1  last pixel of frame

Behaviour:
- The interface is one clock (clk) with a synchronous, active-high reset (rst). All state is updated on the posedge of clk.
- Reset values: busy=0, frame_done=0, pix_valid=0, pix_color=0, pix_sof=0, pix_eol=0, pix_eof=0. FSM=IDLE, all counters 0, snapshot register 0.
- FSM states: IDLE, LOAD, SCAN, DONE.
  - IDLE: on the edge where frame_req=1, copy field into the snapshot register, set busy=1, go to LOAD.
  - LOAD: one cycle. Compute pixel (0,0) from the snapshot, register it, set pix_valid=1 and pix_sof=1, go to SCAN.
  - Latency: pix_valid first high 2 edges after frame_req is sampled.
  - SCAN: a transfer occurs on an edge with pix_valid & pix_ready. On a transfer, advance to the next pixel and load its payload, keeping pix_valid=1.
  - SCAN exit: on transfer of the pixel with pix_eof=1, drop pix_valid and go to DONE.
  - DONE: frame_done=1 for exactly one cycle, busy=0, return to IDLE.
- Raster order: px 0..SIZE_X*CELL_PX-1 within a line, py 0..SIZE_Y*CELL_PX-1. Line-major, top-left first.
- Counter implementation: no dividers. Keep cell_x/sub_x and cell_y/sub_y counters.
  - sub_x wraps at CELL_PX-1 and increments cell_x.
  - At the end of a line, cell_x/sub_x clear and sub_y/cell_y advance likewise.
- Cell bit offset = (cell_y*SIZE_X+cell_x)*3. Widths are $clog2-sized; no counter exceeds its terminal value.
- Colour map:
  - 000 -> {COLOR_W{0}}
  - 001..100 (snake up/right/down/left) -> 12'h0F0
  - 101 (apple) -> 12'hF00
  - 110, 111 (invalid) -> 12'hF0F
- Flags:
  - pix_sof=1 only for pixel (0,0).
  - pix_eol=1 when px is the last column.
  - pix_eof=1 when px and py are both last (pix_eol is also 1 then).
- Backpressure: while pix_valid=1 and pix_ready=0, pix_color and all flags stay stable. pix_valid never deasserts before a transfer.
- Snapshot: changes on field while busy=1 have no effect on the current frame.
- frame_req while busy=1, including in DONE: ignored and not queued. If held high, it is re-sampled in IDLE the cycle after DONE.
- pix_ready is don't-care while pix_valid=0.
- Pixels per frame: exactly SIZE_X*SIZE_Y*CELL_PX^2 transfers (1600 at defaults).
- rst mid-frame: returns to reset values on the next edge. No frame_done is emitted.

Test Plan:
1. Reset: assert rst 2 cycles with frame_req=1 -> all outputs 0 during reset. After release, busy=1 one edge after frame_req is sampled.
2. Content mapping: apple at cell (0,0), code 2 in cells (1..4,1), rest 0; pix_ready=1.
   - pixel (0,0)=12'hF00 with pix_sof=1
   - pixel (4,4)=12'h0F0
   - pixel (3,4)=12'h000
   - pixel (39,39)=12'h000 with pix_eof=1 and pix_eol=1
   - exactly 1600 transfers, 40 pix_eol pulses, then one frame_done pulse
3. Backpressure: pix_ready random at 30% duty -> still exactly 1600 transfers. Payload and flags are unchanged across every stalled cycle, and the sequence is identical to the pix_ready=1 run.
4. Snapshot isolation: change every cell to 101 after the 100th transfer -> the remaining pixels still match the original field. The next frame shows all 12'hF00.
5. Request handling and invalid codes: pulse frame_req at transfers 10 and 1599, with cell (9,9)=110.
   - no restart at transfer 10
   - frame_done exactly once
   - pixels of cell (9,9) = 12'hF0F
   - holding frame_req high starts the next frame right after DONE
6. Reset mid-frame: assert rst at transfer 500 -> pix_valid=0 and busy=0 the next edge, no frame_done. A new frame_req restarts at pixel (0,0) with pix_sof=1.
